lgn_argmax_seq: RTL and testbench

Sequential, parametrised successor to the combinational popcount/arg-max stage that follows the logic-gate network. It counts the set bits of each category's output slice CHUNK bits per cycle, tracks the best and second-best totals, and reports the winning index, its score and the winning margin. A start/busy/done handshake replaces the single-cycle combinational tree. Area scales with CHUNK rather than CATEGORIES×BITS_PER_CATEGORY.

---
 rtl/lgn_argmax_seq.sv | 157 +++++++++++++++
 tb/tb_lgn_argmax_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lgn_argmax_seq.sv
// Sequential popcount / arg-max stage behind the logic-gate network, CHUNK bits per cycle.
// Latency: CATEGORIES*NCHUNK cycles from the start edge to the results edge, then a one-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE or DONE, and y_categories must be held while busy.
module lgn_argmax_seq #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 800,
  parameter int CHUNK             = 32,
  localparam int NCHUNK = (BITS_PER_CATEGORY + CHUNK - 1) / CHUNK,
  localparam int SUM_W  = $clog2(BITS_PER_CATEGORY + 1),
  localparam int IDX_W  = $clog2(CATEGORIES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] y_categories,
  output logic                                  busy,
  output logic                                  done,
  output logic [IDX_W-1:0]                      best_index,
  output logic [SUM_W-1:0]                      best_value,
  output logic [SUM_W-1:0]                      margin
);

  localparam int KW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PADW = NCHUNK * CHUNK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [IDX_W-1:0]  c_q, c_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  run_best_q, run_best_d;
  logic [SUM_W-1:0]  run_second_q, run_second_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic [IDX_W-1:0]  best_index_q, best_index_d;
  logic [SUM_W-1:0]  best_value_q, best_value_d;
  logic [SUM_W-1:0]  margin_q, margin_d;

  logic [BITS_PER_CATEGORY-1:0] cat_slice;
  logic [PADW-1:0]              cat_pad;
  logic [CHUNK-1:0]             chunk_bits;
  logic [SUM_W-1:0]             chunk_pop;
  logic [SUM_W-1:0]             total;
  logic                         last_chunk;
  logic                         last_cat;

  // Select the current chunk of the current category and popcount it; padding above the slice is zero.
  always_comb begin
    cat_slice  = y_categories[int'(c_q)*BITS_PER_CATEGORY +: BITS_PER_CATEGORY];
    cat_pad    = PADW'(cat_slice);
    chunk_bits = cat_pad[int'(k_q)*CHUNK +: CHUNK];
    chunk_pop  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + SUM_W'(chunk_bits[i]);
    end
    total      = acc_q + chunk_pop;
    last_chunk = (k_q == KW'(NCHUNK - 1));
    last_cat   = (c_q == IDX_W'(CATEGORIES - 1));
  end

  // Next-state logic: walk chunks then categories, folding each category total into best/second.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    acc_d        = acc_q;
    run_best_d   = run_best_q;
    run_second_d = run_second_q;
    run_idx_d    = run_idx_q;
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    margin_d     = margin_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        acc_d        = '0;
        k_d          = '0;
        c_d          = '0;
        run_best_d   = '0;
        run_second_d = '0;
        run_idx_d    = '0;
        state_d      = start ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (last_chunk) begin
          if (c_q == '0) begin
            run_best_d   = total;
            run_idx_d    = '0;
            run_second_d = '0;
          end else if (total > run_best_q) begin
            run_second_d = run_best_q;
            run_best_d   = total;
            run_idx_d    = c_q;
          end else if (total > run_second_q) begin
            // A tie with run_best lands here and yields a zero margin.
            run_second_d = total;
          end
          acc_d = '0;
          k_d   = '0;
          if (last_cat) begin
            c_d          = '0;
            state_d      = ST_DONE;
            best_index_d = run_idx_d;
            best_value_d = run_best_d;
            margin_d     = run_best_d - run_second_d;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          acc_d = total;
          k_d   = k_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and clears the published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      run_best_q   <= '0;
      run_second_q <= '0;
      run_idx_q    <= '0;
      best_index_q <= '0;
      best_value_q <= '0;
      margin_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      run_best_q   <= run_best_d;
      run_second_q <= run_second_d;
      run_idx_q    <= run_idx_d;
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
      margin_q     <= margin_d;
    end
  end

  assign busy       = (state_q == ST_COUNT);
  assign done       = (state_q == ST_DONE);
  assign best_index = best_index_q;
  assign best_value = best_value_q;
  assign margin     = margin_q;

endmodule

// File: tb/tb_lgn_argmax_seq.sv
// Bench for lgn_argmax_seq: default-parameter instance plus a small instance with a partial last chunk.
// Expected results come from a whole-vector popcount / arg-max model over plain arrays.
// Each scenario is its own task; all run in sequence from one initial block.
module tb_lgn_argmax_seq;

  localparam int CAT  = 10;
  localparam int BPC  = 800;
  localparam int CH   = 32;
  localparam int TOT  = CAT * BPC;
  localparam int LAT  = CAT * ((BPC + CH - 1) / CH);
  localparam int SLAT = 2 * 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [TOT-1:0] y = '0;
  logic           busy, done;
  logic [3:0]     best_index;
  logic [9:0]     best_value, margin;

  logic           s_start = 1'b0;
  logic [39:0]    s_y = '0;
  logic           s_busy, s_done;
  logic [0:0]     s_idx;
  logic [4:0]     s_val, s_margin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lgn_argmax_seq #(.CATEGORIES(CAT), .BITS_PER_CATEGORY(BPC), .CHUNK(CH)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_categories(y),
    .busy(busy), .done(done), .best_index(best_index), .best_value(best_value), .margin(margin)
  );

  lgn_argmax_seq #(.CATEGORIES(2), .BITS_PER_CATEGORY(20), .CHUNK(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .y_categories(s_y),
    .busy(s_busy), .done(s_done), .best_index(s_idx), .best_value(s_val), .margin(s_margin)
  );

  // Reference: popcount each class over the whole slice, lowest index of the maximum wins,
  // second is the largest count among all other classes.
  function automatic void model(input logic [TOT-1:0] yv, output int idx, output int bv, output int mg);
    int cnt[CAT];
    int sec;
    for (int c = 0; c < CAT; c++) begin
      cnt[c] = 0;
      for (int b = 0; b < BPC; b++) cnt[c] += int'(yv[c*BPC + b]);
    end
    bv = -1; idx = 0;
    for (int c = 0; c < CAT; c++) if (cnt[c] > bv) begin bv = cnt[c]; idx = c; end
    sec = 0;
    for (int c = 0; c < CAT; c++) if (c != idx && cnt[c] > sec) sec = cnt[c];
    mg = bv - sec;
  endfunction

  function automatic logic [TOT-1:0] fill_ones(input logic [TOT-1:0] yv, input int c, input int n);
    logic [TOT-1:0] r;
    r = yv;
    for (int b = 0; b < BPC; b++) r[c*BPC + b] = (b < n);
    return r;
  endfunction

  // Pulse start across one edge (edge 0); returns at edge 0 + 1 time unit.
  task automatic start_big();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // From edge 0: count edges until done, optionally pulsing start at edge pulse_at.
  task automatic wait_done(input int pulse_at, output int lat, output int busy_cnt, output bit overlap);
    lat = -1; busy_cnt = int'(busy); overlap = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      start = (n == pulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (best_index !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", best_index); end
    checks++; if (best_value !== 10'd0) begin errors++; $display("FAIL reset_val got %0d want 0", best_value); end
    checks++; if (margin !== 10'd0) begin errors++; $display("FAIL reset_margin got %0d want 0", margin); end
    checks++; if ({s_busy, s_done, s_idx, s_val, s_margin} !== 13'd0) begin
      errors++; $display("FAIL reset_small got %0h want 0", {s_busy, s_done, s_idx, s_val, s_margin});
    end
  endtask

  // Runs one classification on the default instance and checks timing and results against the model.
  task automatic test_run(input string name, input logic [TOT-1:0] yv);
    int lat, bc, ei, ev, em; bit ov;
    y = yv;
    model(yv, ei, ev, em);
    start_big();
    wait_done(0, lat, bc, ov);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    checks++; if (bc !== LAT) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, LAT); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s_busy_done_overlap got 1 want 0", name); end
    checks++; if (int'(best_index) !== ei) begin errors++; $display("FAIL %s_idx got %0d want %0d", name, best_index, ei); end
    checks++; if (int'(best_value) !== ev) begin errors++; $display("FAIL %s_val got %0d want %0d", name, best_value, ev); end
    checks++; if (int'(margin) !== em) begin errors++; $display("FAIL %s_margin got %0d want %0d", name, margin, em); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse_width got 1 want 0", name); end
  endtask

  task automatic test_spec_patterns();
    logic [TOT-1:0] v;
    int ei, ev, em;
    test_run("zeros", '0);
    checks++; if ({best_index, best_value, margin} !== 24'd0) begin
      errors++; $display("FAIL zeros_const got %0d/%0d/%0d want 0/0/0", best_index, best_value, margin);
    end
    v = fill_ones('0, 7, BPC);
    test_run("cat7", v);
    checks++; if (best_index !== 4'd7 || best_value !== 10'd800 || margin !== 10'd800) begin
      errors++; $display("FAIL cat7_const got %0d/%0d/%0d want 7/800/800", best_index, best_value, margin);
    end
    v = fill_ones('0, 3, 400); v = fill_ones(v, 5, 400); v = fill_ones(v, 9, 399);
    model(v, ei, ev, em);
    test_run("tie", v);
    checks++; if (best_index !== 4'd3 || best_value !== 10'd400 || margin !== 10'd0) begin
      errors++; $display("FAIL tie_const got %0d/%0d/%0d want 3/400/0", best_index, best_value, margin);
    end
  endtask

  task automatic test_random();
    logic [TOT-1:0] v;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < TOT/32; w++) v[w*32 +: 32] = $urandom;
      test_run("rand", v);
    end
    // Counts clustered in a narrow band so ties and near-ties occur often.
    for (int r = 0; r < 3; r++) begin
      v = '0;
      for (int c = 0; c < CAT; c++) v = fill_ones(v, c, $urandom_range(395, 400));
      test_run("near_tie", v);
    end
  endtask

  task automatic small_run(input string name, input logic [39:0] v, input int ei, input int ev, input int em);
    int lat;
    s_y = v;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (s_done) begin lat = n; break; end
    end
    checks++; if (lat !== SLAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, SLAT); end
    checks++; if (int'(s_idx) !== ei) begin errors++; $display("FAIL %s_idx got %0d want %0d", name, s_idx, ei); end
    checks++; if (int'(s_val) !== ev) begin errors++; $display("FAIL %s_val got %0d want %0d", name, s_val, ev); end
    checks++; if (int'(s_margin) !== em) begin errors++; $display("FAIL %s_margin got %0d want %0d", name, s_margin, em); end
  endtask

  task automatic test_partial_chunk();
    logic [39:0] v;
    v = '0; v[20+16 +: 4] = 4'hF; v[19] = 1'b1;
    small_run("partial", v, 1, 4, 3);
    // Category 1 low bits sit just above category 0's last partial chunk and must not be counted there.
    v[20 +: 4] = 4'hF;
    small_run("no_leak", v, 1, 8, 7);
  endtask

  task automatic test_back_to_back();
    logic [TOT-1:0] v1, v2;
    int lat, bc, ei, ev, em; bit ov;
    for (int w = 0; w < TOT/32; w++) v1[w*32 +: 32] = $urandom;
    v2 = fill_ones('0, 6, 123); v2 = fill_ones(v2, 1, 77);
    y = v1;
    model(v1, ei, ev, em);
    start_big();
    wait_done(50, lat, bc, ov);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_start_latency got %0d want %0d", lat, LAT); end
    checks++; if (int'(best_index) !== ei || int'(best_value) !== ev || int'(margin) !== em) begin
      errors++; $display("FAIL ignore_start_result got %0d/%0d/%0d want %0d/%0d/%0d", best_index, best_value, margin, ei, ev, em);
    end
    // Still in the done cycle: present new data and hold start for the next edge.
    y = v2;
    start_big();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b want 1", busy); end
    wait_done(0, lat, bc, ov);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    checks++; if (best_index !== 4'd6 || best_value !== 10'd123 || margin !== 10'd46) begin
      errors++; $display("FAIL b2b_result got %0d/%0d/%0d want 6/123/46", best_index, best_value, margin);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [TOT-1:0] v;
    v = fill_ones('0, 2, 500); v = fill_ones(v, 8, 100);
    test_run("pre_abort", v);
    v = fill_ones('0, 4, 300); v = fill_ones(v, 0, 299);
    y = v;
    start_big();
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_flags got busy=%0b done=%0b want 0/0", busy, done);
    end
    checks++; if ({best_index, best_value, margin} !== 24'd0) begin
      errors++; $display("FAIL abort_outputs got %0d/%0d/%0d want 0/0/0", best_index, best_value, margin);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_run("post_abort", v);
    checks++; if (best_index !== 4'd4 || best_value !== 10'd300 || margin !== 10'd1) begin
      errors++; $display("FAIL post_abort_const got %0d/%0d/%0d want 4/300/1", best_index, best_value, margin);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_spec_patterns();
    test_random();
    test_partial_chunk();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
